apb_bus_arbiter: RTL and testbench



---
 rtl/apb_bus_arbiter_if.sv | 33 +++
 rtl/apb_bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_apb_bus_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_bus_arbiter_if.sv
// Bundle of requester-side and APB-side signals around the APB bus arbiter.
// The master modport is the arbiter's view; slave is the requesters plus the APB slave.
interface apb_bus_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ-1:0]        req_write;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        grant;
  logic [NREQ-1:0]        done;
  logic                   err;
  logic [DATA_W-1:0]      rdata;
  logic                   PSEL;
  logic                   PENABLE;
  logic                   PWRITE;
  logic [ADDR_W-1:0]      PADDR;
  logic [DATA_W-1:0]      PWDATA;
  logic [DATA_W-1:0]      PRDATA;
  logic                   PREADY;

  modport master (
    input  req, req_addr, req_write, req_wdata, PRDATA, PREADY,
    output grant, done, err, rdata, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output req, req_addr, req_write, req_wdata, PRDATA, PREADY,
    input  grant, done, err, rdata, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_bus_arbiter.sv
// Round-robin arbiter that shares one APB bus between NREQ requesters,
// running SETUP/ACCESS transfers with a wait-state timeout.
//
// state  | meaning
// IDLE   | bus free, pick next requester round-robin from rr_ptr
// SETUP  | PSEL high, latched address/data/direction on the bus
// ACCESS | PENABLE high, waiting for PREADY or timeout
module apb_bus_arbiter #(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input logic               CLK,
  input logic               RST,
  apb_bus_arbiter_if.master bus
);
  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [NREQ-1:0]   grant_q, grant_d;

  logic [IDX_W-1:0]  pick_idx;
  logic              pick_vld;
  logic [IDX_W-1:0]  idx_next;
  logic              timeout_hit;
  logic              finish;

  // Scan downward so the last hit written is the one closest to rr_ptr.
  always_comb begin
    int j;
    j        = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (bus.req[j]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(j);
      end
    end
  end

  assign idx_next    = (idx_q == IDX_W'(NREQ - 1)) ? '0 : idx_q + IDX_W'(1);
  assign timeout_hit = (wait_cnt_q == WAIT_W'(TIMEOUT - 1));
  assign finish      = (state_q == ACCESS) && (bus.PREADY || timeout_hit);

  // Completion strobes are combinational so read data returns in the PREADY cycle.
  always_comb begin
    bus.done = '0;
    if (finish) bus.done[idx_q] = 1'b1;
  end

  assign bus.err   = (state_q == ACCESS) && !bus.PREADY && timeout_hit;
  assign bus.rdata = ((state_q == ACCESS) && bus.PREADY) ? bus.PRDATA : '0;

  assign bus.PSEL    = psel_q;
  assign bus.PENABLE = penable_q;
  assign bus.PWRITE  = write_q;
  assign bus.PADDR   = addr_q;
  assign bus.PWDATA  = wdata_q;
  assign bus.grant   = grant_q;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    wait_cnt_d = wait_cnt_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    grant_d    = grant_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d           = SETUP;
          idx_d             = pick_idx;
          addr_d            = bus.req_addr[pick_idx * ADDR_W +: ADDR_W];
          write_d           = bus.req_write[pick_idx];
          wdata_d           = bus.req_wdata[pick_idx * DATA_W +: DATA_W];
          psel_d            = 1'b1;
          penable_d         = 1'b0;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
        end
      end
      SETUP: begin
        state_d    = ACCESS;
        wait_cnt_d = '0;
        penable_d  = 1'b1;
      end
      ACCESS: begin
        if (finish) begin
          state_d   = IDLE;
          rr_ptr_d  = idx_next;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          grant_d   = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      wait_cnt_q <= '0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      wait_cnt_q <= wait_cnt_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      grant_q    <= grant_d;
    end
  end
endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Self-checking bench for apb_bus_arbiter: directed scenarios plus randomized
// transfers checked against a round-robin/timeout reference model.
`timescale 1ns/1ps
module tb_apb_bus_arbiter;
  localparam int NREQ    = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_rr  = 0;

  apb_bus_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_bus_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=time_expired exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic int model_pick(input logic [NREQ-1:0] r, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req       = '0;
    bus.req_addr  = '0;
    bus.req_write = '0;
    bus.req_wdata = '0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.PRDATA = 32'hA5A5_A5A5;
    #1 RST = 1'b1;
    #2;
    n_cmp++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.grant, bus.done, bus.err} !== '0) begin
      n_bad++;
      $display("FAIL reset_ctrl got=%b exp=0", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.grant, bus.done, bus.err});
    end
    n_cmp++;
    if ({bus.PADDR, bus.PWDATA, bus.rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_data got=%h/%h/%h exp=0", bus.PADDR, bus.PWDATA, bus.rdata);
    end
    next_cycle();
    RST  = 1'b0;
    m_rr = 0;
  endtask

  task automatic test_single_read();
    bus.req = 2'b01;
    bus.req_addr[0 +: ADDR_W] = 32'h4;
    bus.PRDATA = 32'hDEAD_BEEF;
    bus.PREADY = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if (bus.PSEL !== 1'b0) begin n_bad++; $display("FAIL rd_c0_psel got=%b exp=0", bus.PSEL); end
    next_cycle();
    @(negedge CLK);
    n_cmp++;
    if ({bus.PSEL, bus.PENABLE, bus.grant, bus.PADDR} !== {2'b10, 2'b01, 32'h4}) begin
      n_bad++;
      $display("FAIL rd_setup got=%b%b/%b/%h exp=10/01/4", bus.PSEL, bus.PENABLE, bus.grant, bus.PADDR);
    end
    next_cycle();
    @(negedge CLK);
    n_cmp++;
    if ({bus.PSEL, bus.PENABLE, bus.done, bus.err, bus.rdata} !== {2'b11, 2'b01, 1'b0, 32'hDEAD_BEEF}) begin
      n_bad++;
      $display("FAIL rd_access got=%b%b/%b/%b/%h exp=11/01/0/deadbeef", bus.PSEL, bus.PENABLE, bus.done, bus.err, bus.rdata);
    end
    next_cycle();
    bus.req = '0;
    @(negedge CLK);
    n_cmp++;
    if ({bus.PSEL, bus.done} !== 3'b000) begin n_bad++; $display("FAIL rd_c3_idle got=%b/%b exp=0/00", bus.PSEL, bus.done); end
    m_rr = 1;
    next_cycle();
  endtask

  task automatic test_write();
    bus.req = 2'b10;
    bus.req_write = 2'b10;
    bus.req_addr[ADDR_W +: ADDR_W]  = 32'h40;
    bus.req_wdata[DATA_W +: DATA_W] = 32'h1234_5678;
    bus.PREADY = 1'b1;
    next_cycle();
    bus.req_wdata[DATA_W +: DATA_W] = 32'hFFFF_0000;
    bus.req_write = 2'b00;
    @(negedge CLK);
    n_cmp++;
    if ({bus.grant, bus.PWRITE, bus.PWDATA} !== {2'b10, 1'b1, 32'h1234_5678}) begin
      n_bad++;
      $display("FAIL wr_setup got=%b/%b/%h exp=10/1/12345678", bus.grant, bus.PWRITE, bus.PWDATA);
    end
    next_cycle();
    @(negedge CLK);
    n_cmp++;
    if ({bus.PWRITE, bus.PWDATA, bus.done, bus.err} !== {1'b1, 32'h1234_5678, 2'b10, 1'b0}) begin
      n_bad++;
      $display("FAIL wr_access got=%b/%h/%b/%b exp=1/12345678/10/0", bus.PWRITE, bus.PWDATA, bus.done, bus.err);
    end
    next_cycle();
    bus.req = '0;
    m_rr = 0;
    next_cycle();
  endtask

  task automatic test_contention();
    int order[6] = '{0, 1, 0, 1, 1, 1};
    bus.req = 2'b11;
    bus.PREADY = 1'b1;
    for (int t = 0; t < 6; t++) begin
      if (t == 4) bus.req = 2'b10;
      @(negedge CLK);
      n_cmp++;
      if (bus.PSEL !== 1'b0) begin n_bad++; $display("FAIL cont_idle t=%0d got=%b exp=0", t, bus.PSEL); end
      next_cycle();
      @(negedge CLK);
      n_cmp++;
      if (bus.grant !== oh(order[t])) begin n_bad++; $display("FAIL cont_grant t=%0d got=%b exp=%b", t, bus.grant, oh(order[t])); end
      next_cycle();
      @(negedge CLK);
      n_cmp++;
      if (bus.done !== oh(order[t])) begin n_bad++; $display("FAIL cont_done t=%0d got=%b exp=%b", t, bus.done, oh(order[t])); end
      next_cycle();
      m_rr = (order[t] + 1) % NREQ;
    end
    bus.req = '0;
    next_cycle();
  endtask

  task automatic test_wait_states();
    bus.req = 2'b01;
    bus.req_addr[0 +: ADDR_W] = 32'h100;
    bus.PRDATA = 32'h0BAD_F00D;
    bus.PREADY = 1'b0;
    next_cycle();
    next_cycle();
    for (int a = 1; a <= 5; a++) begin
      bus.req_addr[0 +: ADDR_W] = $urandom;
      bus.PREADY = (a == 5);
      @(negedge CLK);
      n_cmp++;
      if (bus.PADDR !== 32'h100) begin n_bad++; $display("FAIL ws_paddr a=%0d got=%h exp=100", a, bus.PADDR); end
      n_cmp++;
      if (a < 5 && bus.done !== 2'b00) begin
        n_bad++; $display("FAIL ws_early_done a=%0d got=%b exp=00", a, bus.done);
      end else if (a == 5 && {bus.done, bus.err, bus.rdata} !== {2'b01, 1'b0, 32'h0BAD_F00D}) begin
        n_bad++; $display("FAIL ws_done got=%b/%b/%h exp=01/0/0badf00d", bus.done, bus.err, bus.rdata);
      end
      next_cycle();
    end
    bus.req = '0;
    bus.PREADY = 1'b1;
    m_rr = 1;
    next_cycle();
  endtask

  task automatic test_timeout();
    bus.req = 2'b11;
    bus.PRDATA = 32'h7777_7777;
    bus.PREADY = 1'b0;
    next_cycle();
    @(negedge CLK);
    n_cmp++;
    if (bus.grant !== 2'b10) begin n_bad++; $display("FAIL to_grant got=%b exp=10", bus.grant); end
    next_cycle();
    for (int a = 1; a <= TIMEOUT; a++) begin
      @(negedge CLK);
      n_cmp++;
      if (a < TIMEOUT && {bus.done, bus.err} !== 3'b000) begin
        n_bad++; $display("FAIL to_early a=%0d got=%b/%b exp=00/0", a, bus.done, bus.err);
      end else if (a == TIMEOUT && {bus.done, bus.err, bus.rdata} !== {2'b10, 1'b1, 32'h0}) begin
        n_bad++; $display("FAIL to_abort got=%b/%b/%h exp=10/1/0", bus.done, bus.err, bus.rdata);
      end
      next_cycle();
    end
    bus.PREADY = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if ({bus.PSEL, bus.done, bus.err} !== 4'b0000) begin n_bad++; $display("FAIL to_idle got=%b/%b/%b exp=0", bus.PSEL, bus.done, bus.err); end
    next_cycle();
    @(negedge CLK);
    n_cmp++;
    if (bus.grant !== 2'b01) begin n_bad++; $display("FAIL to_rr_adv got=%b exp=01", bus.grant); end
    next_cycle();
    next_cycle();
    bus.req = '0;
    m_rr = 1;
    next_cycle();
  endtask

  task automatic test_reset_mid();
    bus.req = 2'b11;
    bus.PREADY = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge CLK);
    n_cmp++;
    if ({bus.PSEL, bus.PENABLE, bus.grant} !== 4'b1110) begin n_bad++; $display("FAIL rm_pre got=%b%b/%b exp=11/10", bus.PSEL, bus.PENABLE, bus.grant); end
    #1 RST = 1'b1;
    bus.PREADY = 1'b1;
    #1;
    n_cmp++;
    if ({bus.PSEL, bus.PENABLE, bus.grant, bus.done, bus.err} !== '0) begin
      n_bad++; $display("FAIL rm_async got=%b%b/%b/%b/%b exp=0", bus.PSEL, bus.PENABLE, bus.grant, bus.done, bus.err);
    end
    next_cycle();
    RST = 1'b0;
    m_rr = 0;
    @(negedge CLK);
    n_cmp++;
    if (bus.done !== 2'b00) begin n_bad++; $display("FAIL rm_no_done got=%b exp=00", bus.done); end
    next_cycle();
    @(negedge CLK);
    n_cmp++;
    if (bus.grant !== 2'b01) begin n_bad++; $display("FAIL rm_first_grant got=%b exp=01", bus.grant); end
    next_cycle();
    next_cycle();
    bus.req = '0;
    m_rr = 1;
    next_cycle();
  endtask

  task automatic test_random();
    logic [NREQ-1:0]   r;
    logic [ADDR_W-1:0] eaddr;
    logic [DATA_W-1:0] ewdata, prd;
    logic              ewrite, to;
    int                exp, w, ncyc;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.req = '0;
        bus.PREADY = 1'($urandom);
        @(negedge CLK);
        n_cmp++;
        if ({bus.PSEL, bus.done} !== '0) begin n_bad++; $display("FAIL rnd_gap n=%0d got=%b/%b exp=0", n, bus.PSEL, bus.done); end
        next_cycle();
      end
      r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        bus.req_addr[i*ADDR_W +: ADDR_W]  = $urandom;
        bus.req_wdata[i*DATA_W +: DATA_W] = $urandom;
      end
      bus.req_write = NREQ'($urandom);
      bus.req = r;
      bus.PREADY = 1'($urandom);
      exp    = model_pick(r, m_rr);
      eaddr  = bus.req_addr[exp*ADDR_W +: ADDR_W];
      ewdata = bus.req_wdata[exp*DATA_W +: DATA_W];
      ewrite = bus.req_write[exp];
      prd    = $urandom;
      w      = ($urandom_range(0, 3) == 0) ? 13 + $urandom_range(0, 3) : $urandom_range(0, 17);
      to     = (w >= TIMEOUT);
      ncyc   = to ? TIMEOUT : w + 1;
      @(negedge CLK);
      n_cmp++;
      if ({bus.PSEL, bus.done, bus.err} !== '0) begin n_bad++; $display("FAIL rnd_idle n=%0d got=%b/%b/%b exp=0", n, bus.PSEL, bus.done, bus.err); end
      next_cycle();
      for (int i = 0; i < NREQ; i++) begin
        bus.req_addr[i*ADDR_W +: ADDR_W]  = $urandom;
        bus.req_wdata[i*DATA_W +: DATA_W] = $urandom;
      end
      bus.req_write = NREQ'($urandom);
      bus.PREADY = 1'($urandom);
      @(negedge CLK);
      n_cmp++;
      if ({bus.grant, bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWRITE, bus.PWDATA} !== {oh(exp), 2'b10, eaddr, ewrite, ewdata}) begin
        n_bad++;
        $display("FAIL rnd_setup n=%0d got=%b/%b%b/%h/%b/%h exp=%b/10/%h/%b/%h", n, bus.grant, bus.PSEL, bus.PENABLE,
                 bus.PADDR, bus.PWRITE, bus.PWDATA, oh(exp), eaddr, ewrite, ewdata);
      end
      for (int a = 1; a <= ncyc; a++) begin
        next_cycle();
        bus.PREADY = (a > w);
        bus.PRDATA = prd;
        @(negedge CLK);
        n_cmp++;
        if ({bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWDATA} !== {2'b11, eaddr, ewdata}) begin
          n_bad++; $display("FAIL rnd_hold n=%0d a=%0d got=%h/%h exp=%h/%h", n, a, bus.PADDR, bus.PWDATA, eaddr, ewdata);
        end
        n_cmp++;
        if (a < ncyc && {bus.done, bus.err} !== '0) begin
          n_bad++; $display("FAIL rnd_early n=%0d a=%0d got=%b/%b exp=0", n, a, bus.done, bus.err);
        end else if (a == ncyc && {bus.done, bus.err, bus.rdata} !== {oh(exp), to, to ? 32'h0 : prd}) begin
          n_bad++;
          $display("FAIL rnd_done n=%0d got=%b/%b/%h exp=%b/%b/%h", n, bus.done, bus.err, bus.rdata, oh(exp), to, to ? 32'h0 : prd);
        end
      end
      m_rr = (exp + 1) % NREQ;
      next_cycle();
    end
    bus.req = '0;
    next_cycle();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_write();
    test_contention();
    test_wait_states();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
